data_bus_responder: RTL and testbench

- Memory-side responder for the RV32I data bus: accepts load/store requests from the CPU data port (addr, wdata, size/sign via func3).
- Performs byte-lane store merging and load extraction with sign/zero extension internally; the CPU receives a final register-ready value.
- Adds a req/ready handshake with a programmable wait-state count, so the same RAM serves the planned multi-cycle core and can model slow memory.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/data_bus_responder.sv | 174 +++++++++++++++++
 tb/tb_data_bus_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// RV32I data-bus RAM responder: req/ready handshake with programmable wait states,
// byte-lane store merging, sign/zero-extended loads and access-fault reporting.
module data_bus_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned BW        = AW + 2;
    localparam logic [31:0] BYTE_SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [2:0]      lat_f3;
    logic [BW-1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic            lat_fault;

    logic            misalign_c;
    logic            illegal_c;
    logic            fault_c;
    logic            commit_c;
    logic [3:0]      strb_c;
    logic [31:0]     wlane_c;
    logic [31:0]     word_c;
    logic [31:0]     shifted_c;
    logic [31:0]     load_c;

    logic [31:0]     mem [DEPTH_WORDS];

    // Fault classification of the incoming request
    always_comb begin
        misalign_c = 1'b0;
        illegal_c  = 1'b0;
        case (func3)
            3'b000, 3'b100: misalign_c = 1'b0;
            3'b001, 3'b101: misalign_c = addr[0];
            3'b010:         misalign_c = |addr[1:0];
            default:        illegal_c  = 1'b1;
        endcase
        if (we && func3[2]) begin
            illegal_c = 1'b1;
        end
        fault_c = misalign_c || illegal_c || (addr >= BYTE_SPAN);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            lat_fault <= 1'b0;
        end else if (state == ST_IDLE && req) begin
            cnt       <= CNT_INIT;
            lat_we    <= we;
            lat_f3    <= func3;
            lat_addr  <= addr[BW-1:0];
            lat_wdata <= wdata;
            lat_fault <= fault_c;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Lane strobes and replicated store data
    always_comb begin
        case (lat_f3[1:0])
            2'b00: begin
                strb_c  = 4'b0001 << lat_addr[1:0];
                wlane_c = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                strb_c  = lat_addr[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{lat_wdata[15:0]}};
            end
            default: begin
                strb_c  = 4'b1111;
                wlane_c = lat_wdata;
            end
        endcase
    end

    assign commit_c = (state == ST_RESP) && lat_we && !lat_fault;

    // Store commits on the edge that ends RESP; a coincident reset suppresses it
    always_ff @(posedge clk) begin
        if (commit_c && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_c[b]) begin
                    mem[lat_addr[BW-1:2]][8*b +: 8] <= wlane_c[8*b +: 8];
                end
            end
        end
    end

    assign word_c    = mem[lat_addr[BW-1:2]];
    assign shifted_c = word_c >> {lat_addr[1:0], 3'b000};

    always_comb begin
        case (lat_f3)
            3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b100:  load_c = {24'd0, shifted_c[7:0]};
            3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b101:  load_c = {16'd0, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    // Response outputs decoded from the state register
    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        rdata = 32'd0;
        if (state == ST_RESP) begin
            ready = 1'b1;
            err   = lat_fault;
            if (!lat_we && !lat_fault) begin
                rdata = load_c;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized bench for data_bus_responder: three instances (WAIT_STATES 1, 0, 3)
// checked against a byte-array reference model of the bus rules.
module tb_data_bus_responder;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req;
    logic [2:0]       we;
    logic [2:0]       ready;
    logic [2:0]       err;
    logic [2:0][2:0]  func3;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [3][1024];
    logic [2:0] f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

    always #5 clk = ~clk;

    data_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .func3(func3[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
    );
    data_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .func3(func3[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
    );
    data_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .func3(func3[2]),
        .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .err(err[2])
    );

    function automatic int ws_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, sized access, extension by func3
    task automatic ref_acc(input int i, input bit w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n;
        bit sgn;
        bit bad;
        logic [31:0] v;
        n = 1; sgn = 0; bad = 0;
        case (f3)
            3'd0:    begin n = 1; sgn = 1; end
            3'd1:    begin n = 2; sgn = 1; end
            3'd2:    n = 4;
            3'd4:    n = 1;
            3'd5:    n = 2;
            default: bad = 1;
        endcase
        if (w && (f3 == 3'd4 || f3 == 3'd5)) bad = 1;
        e  = bad || ((a % 32'(n)) != 0) || (a >= 32'd1024);
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int k = 0; k < n; k++) mdl[i][int'(a) + k] = d[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[i][int'(a) + k];
                if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                rd = v;
            end
        end
    endtask

    // One bus access; starts and ends on a falling edge, checks latency, pulse width and data
    task automatic acc(input int i, input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e);
        logic [31:0] exp_rd;
        logic        exp_e;
        int          lat;
        bit          seen;
        ref_acc(i, w, f3, a, d, exp_rd, exp_e);
        req[i] = 1'b1; we[i] = w; func3[i] = f3; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        lat = 0; seen = 0; rd = 32'd0; e = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ready[i] === 1'b1) begin
                seen = 1;
                rd   = rdata[i];
                e    = err[i];
            end
        end
        req[i] = 1'b0;
        check_eq("latency", 32'(lat), 32'(1 + ws_of(i)));
        if (seen) begin
            check_eq("err", 32'(e), 32'(exp_e));
            check_eq("rdata", rd, exp_rd);
        end
        @(negedge clk);
        check_eq("ready_pulse", 32'(ready[i]), 32'd0);
        check_eq("rdata_idle", rdata[i], 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h400 + 32'($urandom_range(0, 255));
        if (r == 1) return {1'b1, 31'($urandom)};
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [31:0] rd;
        logic        e;
        int          pulses;

        reset = 1'b1;
        req = '0; we = '0; func3 = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("reset_ready", 32'(ready[i]), 32'd0);
            check_eq("reset_err", 32'(err[i]), 32'd0);
            check_eq("reset_rdata", rdata[i], 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 64; k++)
                acc(i, 1'b1, 3'd2, 32'(k * 4), $urandom, rd, e);

        acc(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, e);
        check_eq("sw_err", 32'(e), 32'd0);
        acc(0, 1'b0, 3'd2, 32'h10, 32'd0, rd, e);
        check_eq("lw_10", rd, 32'hDEADBEEF);

        acc(0, 1'b1, 3'd2, 32'h20, 32'h11223344, rd, e);
        acc(0, 1'b1, 3'd0, 32'h22, 32'h000000A5, rd, e);
        acc(0, 1'b0, 3'd2, 32'h20, 32'd0, rd, e);
        check_eq("sb_lw", rd, 32'h11A53344);
        acc(0, 1'b0, 3'd0, 32'h22, 32'd0, rd, e);
        check_eq("sb_lb", rd, 32'hFFFFFFA5);
        acc(0, 1'b0, 3'd4, 32'h22, 32'd0, rd, e);
        check_eq("sb_lbu", rd, 32'h000000A5);

        acc(0, 1'b1, 3'd2, 32'h04, 32'h00000000, rd, e);
        acc(0, 1'b1, 3'd1, 32'h06, 32'h00008001, rd, e);
        acc(0, 1'b0, 3'd2, 32'h04, 32'd0, rd, e);
        check_eq("sh_lw", rd, 32'h80010000);
        acc(0, 1'b0, 3'd1, 32'h06, 32'd0, rd, e);
        check_eq("sh_lh", rd, 32'hFFFF8001);
        acc(0, 1'b0, 3'd5, 32'h06, 32'd0, rd, e);
        check_eq("sh_lhu", rd, 32'h00008001);

        acc(0, 1'b0, 3'd2, 32'h02, 32'd0, rd, e);
        check_eq("lw_mis_err", 32'(e), 32'd1);
        check_eq("lw_mis_rdata", rd, 32'd0);
        acc(0, 1'b1, 3'd1, 32'h03, 32'h0000BEEF, rd, e);
        check_eq("sh_mis_err", 32'(e), 32'd1);
        acc(0, 1'b0, 3'd2, 32'h00, 32'd0, rd, e);
        acc(0, 1'b0, 3'd2, 32'h400, 32'd0, rd, e);
        check_eq("oor_err", 32'(e), 32'd1);
        acc(0, 1'b1, 3'd4, 32'h10, 32'h00000055, rd, e);
        check_eq("sbu_err", 32'(e), 32'd1);
        acc(0, 1'b0, 3'd2, 32'h10, 32'd0, rd, e);
        check_eq("sbu_nowrite", rd, 32'hDEADBEEF);

        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 80; n++)
                acc(i, 1'($urandom_range(0, 1)), f3tab[$urandom_range(0, 9)], rand_addr(), $urandom, rd, e);

        // Reset during the wait state of a store aborts it
        acc(0, 1'b1, 3'd2, 32'h30, 32'hCAFEF00D, rd, e);
        req[0] = 1'b1; we[0] = 1'b1; func3[0] = 3'd2; addr[0] = 32'h30; wdata[0] = 32'h12345678;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_ready_async", 32'(ready[0]), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready[0] === 1'b1) pulses++;
        end
        req[0] = 1'b0;
        reset  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready[0] === 1'b1) pulses++;
        end
        check_eq("rst_no_ready", 32'(pulses), 32'd0);
        acc(0, 1'b0, 3'd2, 32'h30, 32'd0, rd, e);
        check_eq("rst_no_write", rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
